// File: rtl/if_id_stage_reg.sv
// if_id_stage_reg: IF/ID valid/ready pipeline register with an optional 2-entry skid mode
// and a saturating downstream-stall counter.
module if_id_stage_reg #(
   parameter int              OP_W    = 32,
   parameter int              PC_W    = 32,
   parameter logic [OP_W-1:0] NOP_VAL = {OP_W{1'b0}},
   parameter int              SKID    = 0,
   parameter int              CNT_W   = 16
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [OP_W-1:0]  in_op_i,
   input  logic [PC_W-1:0]  in_pc_i,
   input  logic             flush_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [OP_W-1:0]  out_op_o,
   output logic [PC_W-1:0]  out_pc_o,
   input  logic             clr_cnt_i,
   output logic [CNT_W-1:0] stall_cnt_o
);
   typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} state_t;
   state_t           state_q, state_d;
   logic [OP_W-1:0]  op_q, op_d, sop_q, sop_d;
   logic [PC_W-1:0]  pc_q, pc_d, spc_q, spc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rdy_q, rdy_d, in_fire, out_fire;

   assign out_valid_o = state_q != ST_EMPTY;
   assign in_ready_o  = (SKID != 0) ? rdy_q : (~out_valid_o | out_ready_i);
   assign in_fire     = in_valid_i & in_ready_o;
   assign out_fire    = out_valid_o & out_ready_i;
   assign out_op_o    = op_q;
   assign out_pc_o    = pc_q;
   assign stall_cnt_o = cnt_q;

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      pc_d    = pc_q;
      sop_d   = sop_q;
      spc_d   = spc_q;
      if (flush_i) begin
         state_d = ST_EMPTY;
         op_d    = NOP_VAL;
      end else begin
         case (state_q)
            ST_EMPTY: if (in_fire) begin
               state_d = ST_FULL;
               op_d    = in_op_i;
               pc_d    = in_pc_i;
            end
            ST_FULL: if (in_fire && out_fire) begin
               op_d = in_op_i;
               pc_d = in_pc_i;
            end else if (in_fire) begin
               // only reachable with SKID=1: a combinational in_ready implies out_fire here
               state_d = ST_SKID;
               sop_d   = in_op_i;
               spc_d   = in_pc_i;
            end else if (out_fire) begin
               state_d = ST_EMPTY;
               op_d    = NOP_VAL;
            end
            ST_SKID: if (out_fire) begin
               state_d = ST_FULL;
               op_d    = sop_q;
               pc_d    = spc_q;
            end
            default: state_d = ST_EMPTY;
         endcase
      end
      rdy_d = state_d != ST_SKID;
      cnt_d = clr_cnt_i ? '0 : (out_valid_o & ~out_ready_i & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_EMPTY;
         op_q    <= NOP_VAL;
         pc_q    <= '0;
         sop_q   <= NOP_VAL;
         spc_q   <= '0;
         cnt_q   <= '0;
         rdy_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         pc_q    <= pc_d;
         sop_q   <= sop_d;
         spc_q   <= spc_d;
         cnt_q   <= cnt_d;
         rdy_q   <= rdy_d;
      end
   end
endmodule
